// File: rtl/kgp_risc_pkg.sv
// rtl/kgp_risc_pkg.sv - shared KGP-RISC datapath constants and write-back request type
package kgp_risc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic req_hit(input wb_req_t req, input logic [ADDR_W-1:0] addr);
    return req.valid && (req.addr == addr);
  endfunction

endpackage

// File: rtl/reg_file_wb_buf.sv
// rtl/reg_file_wb_buf.sv - one-entry pending write buffer: capture, commit strobe, flush, read-port match
module reg_file_wb_buf
  import kgp_risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output wb_req_t           o_pend,
  output logic              o_commit,
  output logic              o_rs_hit,
  output logic              o_rt_hit
);

  wb_req_t r_pend;
  logic    w_capture;

  // Writes to the zero register are dropped here so they never appear as pending.
  assign w_capture = i_wr_en && (i_wr_addr != REG_ZERO) && !i_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
    end else if (w_capture) begin
      r_pend <= {1'b1, i_wr_addr, i_wr_data};
    end else begin
      r_pend.valid <= 1'b0;
    end
  end

  assign o_pend   = r_pend;
  assign o_commit = r_pend.valid && !i_flush;
  assign o_rs_hit = req_hit(r_pend, i_rs_addr);
  assign o_rt_hit = req_hit(r_pend, i_rt_addr);

endmodule

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - 32-entry write-back register file, two combinational read ports; REGFILE_BYPASS_EN enables pending-write bypass
module reg_file_wb #(
  parameter int DATA_W = kgp_risc_pkg::DATA_W,
  parameter int ADDR_W = kgp_risc_pkg::ADDR_W,
  parameter int NREGS  = kgp_risc_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr
);

  import kgp_risc_pkg::*;

  logic [DATA_W-1:0] r_regs [NREGS];

  wb_req_t w_pend;
  logic    w_commit;
  logic    w_rs_hit;
  logic    w_rt_hit;
  logic    w_rs_byp;
  logic    w_rt_byp;

  reg_file_wb_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_flush   (flush),
    .i_rs_addr (rs_addr),
    .i_rt_addr (rt_addr),
    .o_pend    (w_pend),
    .o_commit  (w_commit),
    .o_rs_hit  (w_rs_hit),
    .o_rt_hit  (w_rt_hit)
  );

`ifdef REGFILE_BYPASS_EN
  assign w_rs_byp = w_rs_hit;
  assign w_rt_byp = w_rt_hit;
`else
  // Without bypass the match is left to external hazard logic via pend_valid/pend_addr.
  logic w_unused_hits;
  assign w_unused_hits = w_rs_hit ^ w_rt_hit;
  assign w_rs_byp      = 1'b0;
  assign w_rt_byp      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[w_pend.addr] <= w_pend.data;
    end
  end

  always_comb begin
    rs_data = r_regs[rs_addr];
    if (rs_addr == REG_ZERO) begin
      rs_data = '0;
    end else if (w_rs_byp) begin
      rs_data = w_pend.data;
    end
  end

  always_comb begin
    rt_data = r_regs[rt_addr];
    if (rt_addr == REG_ZERO) begin
      rt_data = '0;
    end else if (w_rt_byp) begin
      rt_data = w_pend.data;
    end
  end

  assign pend_valid = w_pend.valid;
  assign pend_addr  = w_pend.addr;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - randomized and directed checks of reg_file_wb against a behavioural model
module tb_reg_file_wb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] rs_addr = '0;
  logic [AW-1:0] rt_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  reg_file_wb dut (
    .clk        (clk),
    .rst        (rst),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flush      (flush),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr)
  );

  // Behavioural model: architectural registers plus at most one write in flight.
  logic [DW-1:0] m_regs [NR];
  bit            m_pv;
  logic [AW-1:0] m_pa;
  logic [DW-1:0] m_pd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_pv = 1'b0;
      m_pa = '0;
      m_pd = '0;
    end else begin
      if (m_pv && !flush) m_regs[m_pa] = m_pd;
      if (wr_en && wr_addr != 0 && !flush) begin
        m_pv = 1'b1;
        m_pa = wr_addr;
        m_pd = wr_data;
      end else begin
        m_pv = 1'b0;
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYP && m_pv && a == m_pa) return m_pd;
    return m_regs[a];
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rs_data", rs_data, exp_rd(rs_addr));
      chk("rt_data", rt_data, exp_rd(rt_addr));
      chk("pend_valid", {31'b0, pend_valid}, {31'b0, m_pv});
      if (m_pv || !rst) chk("pend_addr", {27'b0, pend_addr}, {27'b0, m_pa});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] last_a = '0;
  logic [AW-1:0] prev_a = '0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_pend_valid", {31'b0, pend_valid}, 32'h0);
    chk("rst_rs0", rs_data, 32'h0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < NR; i++) begin
      rs_addr = AW'(i);
      rt_addr = AW'(NR - 1 - i);
      @(negedge clk);
      chk("reset_read_rs", rs_data, 32'h0);
      chk("reset_read_rt", rt_data, 32'h0);
      tick();
    end

    // Write then read, addr 5.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs_addr = 5'd5;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("wr5_n1", rs_data, BYP ? 32'hDEADBEEF : 32'h0);
    chk("wr5_pv", {31'b0, pend_valid}, 32'h1);
    tick();
    @(negedge clk);
    chk("wr5_n2", rs_data, 32'hDEADBEEF);
    tick();

    // Zero register.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rs_addr = 5'd0; rt_addr = 5'd0;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("zero_pv", {31'b0, pend_valid}, 32'h0);
    chk("zero_rs", rs_data, 32'h0);
    tick();
    @(negedge clk);
    chk("zero_rt", rt_data, 32'h0);
    tick();

    // Back-to-back same address.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1; rt_addr = 5'd7;
    tick();
    wr_data = 32'h2;
    @(negedge clk);
    chk("b2b_n1", rt_data, BYP ? 32'h1 : 32'h0);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("b2b_n2", rt_data, BYP ? 32'h2 : 32'h1);
    tick();
    @(negedge clk);
    chk("b2b_settle", rt_data, 32'h2);
    tick();

    // Flush cancels the pending write.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA; rs_addr = 5'd9;
    tick();
    wr_en = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_pv_before", {31'b0, pend_valid}, 32'h1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_pv_after", {31'b0, pend_valid}, 32'h0);
    chk("flush_r9", rs_data, 32'h0);
    tick();
    @(negedge clk);
    chk("flush_r9_late", rs_data, 32'h0);
    tick();

    // Asynchronous reset while a write is pending.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; rs_addr = 5'd3; rt_addr = 5'd5;
    tick();
    wr_en = 1'b0;
    chk("arst_pv_before", {31'b0, pend_valid}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_r3", rs_data, 32'h0);
    chk("arst_r5", rt_data, 32'h0);
    chk("arst_pv", {31'b0, pend_valid}, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Randomized traffic with reads steered at recent write addresses.
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom % 10) < 7;
      wr_addr = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wr_data = $urandom;
      flush   = ($urandom % 10) == 0;
      case ($urandom % 3)
        0:       rs_addr = last_a;
        1:       rs_addr = prev_a;
        default: rs_addr = AW'($urandom);
      endcase
      rt_addr = ($urandom % 2) ? last_a : AW'($urandom_range(0, 7));
      prev_a  = last_a;
      last_a  = wr_addr;
      if ($urandom % 400 == 0) begin
        #2 rst = 1'b0;
        #1;
        chk("rand_arst_pv", {31'b0, pend_valid}, 32'h0);
      end
      tick();
      rst = 1'b1;
    end

    wr_en = 1'b0;
    flush = 1'b0;
    repeat (3) tick();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
